// File: rtl/alu_control_pkg.sv
// rtl/alu_control_pkg.sv - execution-stage ALU operation encodings
package alu_control_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_PASS = 4'd10
    } alu_op_t;

endpackage : alu_control_pkg

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - core-wide datapath constants
package core_pkg;

    localparam int DATA_WIDTH = 32;

endpackage : core_pkg

// File: rtl/mem_control_pkg.sv
// rtl/mem_control_pkg.sv - memory access size encodings and lane helpers
package mem_control_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } mem_state_t;

    // The unused encoding 3 behaves as a full word access.
    function automatic mem_size_t norm_size(input logic [1:0] raw);
        mem_size_t s;
        case (raw)
            2'd0:    s = MEM_BYTE;
            2'd1:    s = MEM_HALF;
            default: s = MEM_WORD;
        endcase
        return s;
    endfunction

    function automatic logic is_misaligned(input mem_size_t s, input logic [1:0] lo);
        logic m;
        case (s)
            MEM_HALF: m = lo[0];
            MEM_WORD: m = (lo != 2'b00);
            default:  m = 1'b0;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] byte_mask(input mem_size_t s, input logic [1:0] lo);
        logic [3:0] be;
        case (s)
            MEM_BYTE: be = 4'b0001 << lo;
            MEM_HALF: be = 4'b0011 << lo;
            default:  be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the store operand across all lanes; byte enables pick the live ones.
    function automatic logic [31:0] store_lanes(input mem_size_t s, input logic [31:0] d);
        logic [31:0] w;
        case (s)
            MEM_BYTE: w = {4{d[7:0]}};
            MEM_HALF: w = {2{d[15:0]}};
            default:  w = d;
        endcase
        return w;
    endfunction

endpackage : mem_control_pkg

// File: rtl/core_load_align.sv
// rtl/core_load_align.sv - load data lane extraction and sign/zero extension
// Ports:
//   rdata       in  32  raw bus read word
//   addr_lo     in  2   byte offset of the access
//   size        in  mem_size_t access width
//   is_unsigned in  1   zero-extend instead of sign-extend
//   data        out 32  architectural load result
module core_load_align
    import mem_control_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  mem_size_t   size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [31:0] shifted;
    logic        sign_bit;

    always_comb begin
        shifted  = rdata >> {addr_lo, 3'b000};
        sign_bit = 1'b0;
        data     = rdata;
        case (size)
            MEM_BYTE: begin
                sign_bit = shifted[7] & ~is_unsigned;
                data     = {{24{sign_bit}}, shifted[7:0]};
            end
            MEM_HALF: begin
                sign_bit = shifted[15] & ~is_unsigned;
                data     = {{16{sign_bit}}, shifted[15:0]};
            end
            default: data = rdata;
        endcase
    end

endmodule : core_load_align

// File: rtl/core_memory_stage.sv
// rtl/core_memory_stage.sv - pipeline memory stage: data bus access and writeback hand-off
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   ex_valid/ex_ready             execute-stage handshake
//   ex_out, ex_store_data         result/effective address, store operand
//   mem_read, mem_write, mem_size, mem_unsigned, rd_addr, reg_write  op controls
//   dmem_req/we/addr/be/wdata     registered data bus request
//   dmem_rdata, dmem_ack          bus response
//   wb_valid/wb_ready             writeback handshake
//   wb_data, wb_rd, wb_reg_write, wb_misaligned  registered writeback payload
module core_memory_stage
    import mem_control_pkg::*;
#(
    parameter int DATA_WIDTH = core_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [DATA_WIDTH-1:0] ex_out,
    input  logic [DATA_WIDTH-1:0] ex_store_data,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [1:0]            mem_size,
    input  logic                  mem_unsigned,
    input  logic [4:0]            rd_addr,
    input  logic                  reg_write,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DATA_WIDTH-1:0] dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    input  logic                  dmem_ack,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic [4:0]            wb_rd,
    output logic                  wb_reg_write,
    output logic                  wb_misaligned
);

    mem_state_t            state_q, state_d;
    logic                  dmem_req_q, dmem_req_d;
    logic                  dmem_we_q, dmem_we_d;
    logic [DATA_WIDTH-1:0] dmem_addr_q, dmem_addr_d;
    logic [3:0]            dmem_be_q, dmem_be_d;
    logic [DATA_WIDTH-1:0] dmem_wdata_q, dmem_wdata_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
    logic [4:0]            wb_rd_q, wb_rd_d;
    logic                  wb_reg_write_q, wb_reg_write_d;
    logic                  wb_misaligned_q, wb_misaligned_d;

    // Operation context kept for the duration of a bus access.
    logic                  op_load_q, op_load_d;
    mem_size_t             op_size_q, op_size_d;
    logic                  op_unsigned_q, op_unsigned_d;
    logic [4:0]            op_rd_q, op_rd_d;
    logic                  op_reg_write_q, op_reg_write_d;
    logic [DATA_WIDTH-1:0] op_ex_out_q, op_ex_out_d;

    mem_size_t             size_eff;
    logic                  is_mem;
    logic                  accept;
    logic [DATA_WIDTH-1:0] load_data;

    assign ex_ready = (state_q == ST_IDLE) && (!wb_valid_q || wb_ready);
    assign accept   = ex_valid && ex_ready;
    assign size_eff = norm_size(mem_size);
    assign is_mem   = mem_read || mem_write;

    core_load_align u_load_align (
        .rdata       (dmem_rdata),
        .addr_lo     (op_ex_out_q[1:0]),
        .size        (op_size_q),
        .is_unsigned (op_unsigned_q),
        .data        (load_data)
    );

    always_comb begin
        state_d         = state_q;
        dmem_req_d      = dmem_req_q;
        dmem_we_d       = dmem_we_q;
        dmem_addr_d     = dmem_addr_q;
        dmem_be_d       = dmem_be_q;
        dmem_wdata_d    = dmem_wdata_q;
        wb_valid_d      = wb_valid_q;
        wb_data_d       = wb_data_q;
        wb_rd_d         = wb_rd_q;
        wb_reg_write_d  = wb_reg_write_q;
        wb_misaligned_d = wb_misaligned_q;
        op_load_d       = op_load_q;
        op_size_d       = op_size_q;
        op_unsigned_d   = op_unsigned_q;
        op_rd_d         = op_rd_q;
        op_reg_write_d  = op_reg_write_q;
        op_ex_out_d     = op_ex_out_q;

        // Consumed result drops; any new result below overrides this.
        if (wb_valid_q && wb_ready) begin
            wb_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!is_mem) begin
                        wb_valid_d      = 1'b1;
                        wb_data_d       = ex_out;
                        wb_rd_d         = rd_addr;
                        wb_reg_write_d  = reg_write;
                        wb_misaligned_d = 1'b0;
                    end else if (is_misaligned(size_eff, ex_out[1:0])) begin
                        wb_valid_d      = 1'b1;
                        wb_data_d       = ex_out;
                        wb_rd_d         = rd_addr;
                        wb_reg_write_d  = 1'b0;
                        wb_misaligned_d = 1'b1;
                    end else begin
                        state_d        = ST_BUS;
                        dmem_req_d     = 1'b1;
                        dmem_we_d      = mem_write;
                        dmem_addr_d    = {ex_out[DATA_WIDTH-1:2], 2'b00};
                        dmem_be_d      = byte_mask(size_eff, ex_out[1:0]);
                        dmem_wdata_d   = store_lanes(size_eff, ex_store_data);
                        // A read+write op is a store, so it is never a load.
                        op_load_d      = !mem_write;
                        op_size_d      = size_eff;
                        op_unsigned_d  = mem_unsigned;
                        op_rd_d        = rd_addr;
                        op_reg_write_d = reg_write;
                        op_ex_out_d    = ex_out;
                    end
                end
            end
            ST_BUS: begin
                // ex_ready was high at accept, so the wb register is free by now.
                if (dmem_ack) begin
                    state_d         = ST_IDLE;
                    dmem_req_d      = 1'b0;
                    dmem_we_d       = 1'b0;
                    wb_valid_d      = 1'b1;
                    wb_data_d       = op_load_q ? load_data : op_ex_out_q;
                    wb_rd_d         = op_rd_q;
                    wb_reg_write_d  = op_load_q && op_reg_write_q;
                    wb_misaligned_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            dmem_req_q      <= 1'b0;
            dmem_we_q       <= 1'b0;
            dmem_addr_q     <= '0;
            dmem_be_q       <= 4'b0000;
            dmem_wdata_q    <= '0;
            wb_valid_q      <= 1'b0;
            wb_data_q       <= '0;
            wb_rd_q         <= 5'd0;
            wb_reg_write_q  <= 1'b0;
            wb_misaligned_q <= 1'b0;
            op_load_q       <= 1'b0;
            op_size_q       <= MEM_BYTE;
            op_unsigned_q   <= 1'b0;
            op_rd_q         <= 5'd0;
            op_reg_write_q  <= 1'b0;
            op_ex_out_q     <= '0;
        end else begin
            state_q         <= state_d;
            dmem_req_q      <= dmem_req_d;
            dmem_we_q       <= dmem_we_d;
            dmem_addr_q     <= dmem_addr_d;
            dmem_be_q       <= dmem_be_d;
            dmem_wdata_q    <= dmem_wdata_d;
            wb_valid_q      <= wb_valid_d;
            wb_data_q       <= wb_data_d;
            wb_rd_q         <= wb_rd_d;
            wb_reg_write_q  <= wb_reg_write_d;
            wb_misaligned_q <= wb_misaligned_d;
            op_load_q       <= op_load_d;
            op_size_q       <= op_size_d;
            op_unsigned_q   <= op_unsigned_d;
            op_rd_q         <= op_rd_d;
            op_reg_write_q  <= op_reg_write_d;
            op_ex_out_q     <= op_ex_out_d;
        end
    end

    assign dmem_req      = dmem_req_q;
    assign dmem_we       = dmem_we_q;
    assign dmem_addr     = dmem_addr_q;
    assign dmem_be       = dmem_be_q;
    assign dmem_wdata    = dmem_wdata_q;
    assign wb_valid      = wb_valid_q;
    assign wb_data       = wb_data_q;
    assign wb_rd         = wb_rd_q;
    assign wb_reg_write  = wb_reg_write_q;
    assign wb_misaligned = wb_misaligned_q;

endmodule : core_memory_stage
